ex_mem_latch: RTL and testbench

- Execute/memory pipeline register that sits directly downstream of the ALU in each core's 5-stage pipeline.
- Captures the ALU result and flags alongside the EX-stage control fields.
- Resolves conditional branches from the ALU flags and presents registered values to the MEM stage and the hazard unit.
- Implements stall, flush and the data-cache request handshake (request clear on dhit) for that boundary.

---
 rtl/ex_mem_if.sv | 55 +++++
 rtl/ex_mem_latch.sv | 126 ++++++++++++
 tb/tb_ex_mem_latch.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// EX -> MEM boundary bundle: EX-stage inputs to the latch and registered MEM-stage outputs.
interface ex_mem_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              ex_valid;
    logic [WORD_W-1:0] portout;
    logic              zero;
    logic              negative;
    logic              overflow;
    logic [WORD_W-1:0] ex_pc;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwen;
    logic              ex_dren;
    logic              ex_dwen;
    logic [WORD_W-1:0] ex_store_data;
    logic [2:0]        ex_brtype;
    logic [WORD_W-1:0] ex_brtarget;
    logic              ex_ovf_chk;
    logic              ex_halt;
    logic              stall;
    logic              flush;
    logic              dhit;

    logic              mem_valid;
    logic [WORD_W-1:0] mem_aluout;
    logic [WORD_W-1:0] mem_pc;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwen;
    logic              mem_dren;
    logic              mem_dwen;
    logic [WORD_W-1:0] mem_store_data;
    logic              mem_br_taken;
    logic [WORD_W-1:0] mem_br_target;
    logic              mem_halt;
    logic              mem_exc;

    // Upstream pipeline / control side
    modport master (
        output ex_valid, portout, zero, negative, overflow, ex_pc, ex_rd, ex_regwen,
               ex_dren, ex_dwen, ex_store_data, ex_brtype, ex_brtarget, ex_ovf_chk,
               ex_halt, stall, flush, dhit,
        input  mem_valid, mem_aluout, mem_pc, mem_rd, mem_regwen, mem_dren, mem_dwen,
               mem_store_data, mem_br_taken, mem_br_target, mem_halt, mem_exc
    );

    // The pipeline latch itself
    modport slave (
        input  ex_valid, portout, zero, negative, overflow, ex_pc, ex_rd, ex_regwen,
               ex_dren, ex_dwen, ex_store_data, ex_brtype, ex_brtarget, ex_ovf_chk,
               ex_halt, stall, flush, dhit,
        output mem_valid, mem_aluout, mem_pc, mem_rd, mem_regwen, mem_dren, mem_dwen,
               mem_store_data, mem_br_taken, mem_br_target, mem_halt, mem_exc
    );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: branch resolution, stall/flush, dcache request clear on dhit, sticky halt.
// Optional overflow trap enabled by defining ALU_OVF_TRAP_EN.
module ex_mem_latch #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic     CLK,
    input logic     nRST,
    ex_mem_if.slave bus
);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6,
        BR_JUMP = 3'd7
    } br_e;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] aluout;
        logic [WORD_W-1:0] pc;
        logic [REG_AW-1:0] rd;
        logic              regwen;
        logic              dren;
        logic              dwen;
        logic [WORD_W-1:0] store_data;
        logic              br_taken;
        logic [WORD_W-1:0] br_target;
        logic              exc;
    } stage_t;

    stage_t stage_q, stage_d;
    stage_t capture_c;
    logic   halt_q, halt_d;
    logic   br_taken_c;
    logic   ovf_trap_c;

    // Unsigned compares arrive as SLTU, so the result bit is portout[0]
    always_comb begin
        br_taken_c = 1'b0;
        case (br_e'(bus.ex_brtype))
            BR_NONE: br_taken_c = 1'b0;
            BR_EQ:   br_taken_c = bus.zero;
            BR_NE:   br_taken_c = ~bus.zero;
            BR_LT:   br_taken_c = bus.negative ^ bus.overflow;
            BR_GE:   br_taken_c = ~(bus.negative ^ bus.overflow);
            BR_LTU:  br_taken_c = bus.portout[0];
            BR_GEU:  br_taken_c = ~bus.portout[0];
            BR_JUMP: br_taken_c = 1'b1;
        endcase
    end

`ifdef ALU_OVF_TRAP_EN
    assign ovf_trap_c = bus.ex_valid & bus.ex_ovf_chk & bus.overflow;
`else
    logic unused_ovf_chk;
    assign unused_ovf_chk = bus.ex_ovf_chk;
    assign ovf_trap_c     = 1'b0;
`endif

    // Fields captured on a normal load; side effects suppressed for invalid or trapping slots
    always_comb begin
        capture_c            = '0;
        capture_c.valid      = bus.ex_valid;
        capture_c.aluout     = bus.portout;
        capture_c.pc         = bus.ex_pc;
        capture_c.rd         = bus.ex_rd;
        capture_c.regwen     = bus.ex_valid & bus.ex_regwen & ~ovf_trap_c;
        capture_c.dren       = bus.ex_valid & bus.ex_dren & ~ovf_trap_c;
        capture_c.dwen       = bus.ex_valid & bus.ex_dwen & ~ovf_trap_c;
        capture_c.store_data = bus.ex_store_data;
        capture_c.br_taken   = bus.ex_valid & br_taken_c;
        capture_c.br_target  = bus.ex_brtarget;
        capture_c.exc        = ovf_trap_c;
    end

    // Priority flush > stall > load; halt is sticky and turns later loads into bubbles
    always_comb begin
        stage_d = stage_q;
        halt_d  = halt_q;
        if (bus.flush) begin
            stage_d = '0;
        end else if (bus.stall) begin
            if (bus.dhit) begin
                stage_d.dren = 1'b0;
                stage_d.dwen = 1'b0;
            end
        end else if (halt_q) begin
            stage_d = '0;
        end else begin
            stage_d = capture_c;
            if (bus.ex_valid && bus.ex_halt) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stage_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.mem_valid      = stage_q.valid;
    assign bus.mem_aluout     = stage_q.aluout;
    assign bus.mem_pc         = stage_q.pc;
    assign bus.mem_rd         = stage_q.rd;
    assign bus.mem_regwen     = stage_q.regwen;
    assign bus.mem_dren       = stage_q.dren;
    assign bus.mem_dwen       = stage_q.dwen;
    assign bus.mem_store_data = stage_q.store_data;
    assign bus.mem_br_taken   = stage_q.br_taken;
    assign bus.mem_br_target  = stage_q.br_target;
    assign bus.mem_halt       = halt_q;
    assign bus.mem_exc        = stage_q.exc;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed and randomized checks of ex_mem_latch against a behavioural model of the EX/MEM boundary.
module tb_ex_mem_latch;

    logic CLK;
    logic nRST;
    int   n_cmp;
    int   n_err;

    ex_mem_if #(.WORD_W(32), .REG_AW(5)) bus ();

    ex_mem_latch #(.WORD_W(32), .REG_AW(5)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected MEM-stage contents
    logic        e_valid, e_regwen, e_dren, e_dwen, e_br, e_halt, e_exc;
    logic [31:0] e_alu, e_pc, e_sd, e_tgt;
    logic [4:0]  e_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input logic keep_halt);
        e_valid = 0; e_regwen = 0; e_dren = 0; e_dwen = 0; e_br = 0; e_exc = 0;
        e_alu = 0; e_pc = 0; e_sd = 0; e_tgt = 0; e_rd = 0;
        if (!keep_halt) e_halt = 0;
    endtask

    function automatic logic ref_taken(input logic [2:0] t, input logic z, input logic n,
                                       input logic o, input logic [31:0] p);
        logic lt;
        lt = n ^ o;
        case (t)
            3'd1: return z;
            3'd2: return !z;
            3'd3: return lt;
            3'd4: return !lt;
            3'd5: return p[0];
            3'd6: return !p[0];
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Applies the spec's per-edge rules to the current bus inputs
    task automatic model_step();
        logic v, trap;
        v = bus.ex_valid;
`ifdef ALU_OVF_TRAP_EN
        trap = v && bus.ex_ovf_chk && bus.overflow;
`else
        trap = 1'b0;
`endif
        if (bus.flush) begin
            model_clear(1'b1);
        end else if (bus.stall) begin
            if (bus.dhit) begin e_dren = 0; e_dwen = 0; end
        end else if (e_halt) begin
            model_clear(1'b1);
        end else begin
            e_valid  = v;
            e_alu    = bus.portout;
            e_pc     = bus.ex_pc;
            e_rd     = bus.ex_rd;
            e_sd     = bus.ex_store_data;
            e_tgt    = bus.ex_brtarget;
            e_regwen = v && bus.ex_regwen && !trap;
            e_dren   = v && bus.ex_dren && !trap;
            e_dwen   = v && bus.ex_dwen && !trap;
            e_br     = v && ref_taken(bus.ex_brtype, bus.zero, bus.negative, bus.overflow, bus.portout);
            e_exc    = trap;
            e_halt   = v && bus.ex_halt;
        end
    endtask

    task automatic check_model();
        chk("valid",  32'(bus.mem_valid),    32'(e_valid));
        chk("regwen", 32'(bus.mem_regwen),   32'(e_regwen));
        chk("dren",   32'(bus.mem_dren),     32'(e_dren));
        chk("dwen",   32'(bus.mem_dwen),     32'(e_dwen));
        chk("br",     32'(bus.mem_br_taken), 32'(e_br));
        chk("halt",   32'(bus.mem_halt),     32'(e_halt));
        chk("exc",    32'(bus.mem_exc),      32'(e_exc));
        if (e_valid) begin
            chk("aluout", bus.mem_aluout,       e_alu);
            chk("pc",     bus.mem_pc,           e_pc);
            chk("rd",     32'(bus.mem_rd),      32'(e_rd));
            chk("sd",     bus.mem_store_data,   e_sd);
            chk("tgt",    bus.mem_br_target,    e_tgt);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"},  32'(bus.mem_valid),  0);
        chk({tag, ".aluout"}, bus.mem_aluout,      0);
        chk({tag, ".pc"},     bus.mem_pc,          0);
        chk({tag, ".rd"},     32'(bus.mem_rd),     0);
        chk({tag, ".regwen"}, 32'(bus.mem_regwen), 0);
        chk({tag, ".dren"},   32'(bus.mem_dren),   0);
        chk({tag, ".dwen"},   32'(bus.mem_dwen),   0);
        chk({tag, ".sd"},     bus.mem_store_data,  0);
        chk({tag, ".br"},     32'(bus.mem_br_taken), 0);
        chk({tag, ".tgt"},    bus.mem_br_target,   0);
        chk({tag, ".halt"},   32'(bus.mem_halt),   0);
        chk({tag, ".exc"},    32'(bus.mem_exc),    0);
    endtask

    task automatic idle();
        bus.ex_valid = 0; bus.portout = 0; bus.zero = 0; bus.negative = 0; bus.overflow = 0;
        bus.ex_pc = 0; bus.ex_rd = 0; bus.ex_regwen = 0; bus.ex_dren = 0; bus.ex_dwen = 0;
        bus.ex_store_data = 0; bus.ex_brtype = 0; bus.ex_brtarget = 0; bus.ex_ovf_chk = 0;
        bus.ex_halt = 0; bus.stall = 0; bus.flush = 0; bus.dhit = 0;
    endtask

    // One clock: model predicts from inputs, then outputs sampled 1 time unit after the edge
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_model();
    endtask

    task automatic async_reset(input string tag);
        nRST = 1'b0;
        #1;
        model_clear(1'b0);
        check_all_zero(tag);
        nRST = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        nRST  = 1'b0;
        idle();
        model_clear(1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        nRST = 1'b1;

        // ADD
        bus.ex_valid = 1; bus.portout = 32'h10; bus.ex_rd = 5; bus.ex_regwen = 1;
        tick();
        chk("add.aluout", bus.mem_aluout, 32'h10);
        chk("add.rd",     32'(bus.mem_rd), 5);
        chk("add.regwen", 32'(bus.mem_regwen), 1);
        chk("add.valid",  32'(bus.mem_valid), 1);

        // Branches
        idle(); bus.ex_valid = 1; bus.ex_brtype = 3'd1; bus.zero = 1; bus.ex_brtarget = 32'h0000_1000;
        tick();
        chk("beq.taken",  32'(bus.mem_br_taken), 1);
        chk("beq.target", bus.mem_br_target, 32'h0000_1000);
        idle(); bus.ex_valid = 1; bus.ex_brtype = 3'd3; bus.negative = 1; bus.overflow = 1;
        tick();
        chk("blt.taken", 32'(bus.mem_br_taken), 0);
        idle(); bus.ex_valid = 0; bus.ex_brtype = 3'd2; bus.zero = 0;
        tick();
        chk("bne_inv.taken", 32'(bus.mem_br_taken), 0);

        // LW then 3-cycle stall with dhit in the second
        idle(); bus.ex_valid = 1; bus.ex_dren = 1; bus.ex_regwen = 1; bus.portout = 32'h200; bus.ex_rd = 7;
        tick();
        chk("lw.dren", 32'(bus.mem_dren), 1);
        bus.portout = 32'h300; bus.stall = 1;
        tick();
        chk("stall1.dren", 32'(bus.mem_dren), 1);
        chk("stall1.alu",  bus.mem_aluout, 32'h200);
        bus.dhit = 1;
        tick();
        chk("stall2.dren", 32'(bus.mem_dren), 0);
        chk("stall2.alu",  bus.mem_aluout, 32'h200);
        bus.dhit = 0;
        tick();
        chk("stall3.dren", 32'(bus.mem_dren), 0);
        chk("stall3.alu",  bus.mem_aluout, 32'h200);

        // flush + stall with a valid SW
        idle(); bus.ex_valid = 1; bus.ex_dwen = 1; bus.ex_regwen = 1; bus.flush = 1; bus.stall = 1;
        tick();
        chk("flush.valid",  32'(bus.mem_valid), 0);
        chk("flush.dwen",   32'(bus.mem_dwen), 0);
        chk("flush.regwen", 32'(bus.mem_regwen), 0);

        // Sticky halt
        idle(); bus.ex_valid = 1; bus.ex_halt = 1;
        tick();
        chk("halt.set", 32'(bus.mem_halt), 1);
        idle(); bus.ex_valid = 1; bus.ex_regwen = 1; bus.portout = 32'h44;
        tick();
        chk("halt.bubble_valid",  32'(bus.mem_valid), 0);
        chk("halt.bubble_regwen", 32'(bus.mem_regwen), 0);
        chk("halt.hold", 32'(bus.mem_halt), 1);
        idle(); bus.flush = 1;
        tick();
        chk("halt.after_flush", 32'(bus.mem_halt), 1);
        idle();
        async_reset("halt_rst");

        // Reset during a stalled load
        bus.ex_valid = 1; bus.ex_dren = 1; bus.portout = 32'h80;
        tick();
        bus.stall = 1;
        tick();
        async_reset("stall_rst");
        idle();

        // Overflow-checked ADD
        bus.ex_valid = 1; bus.ex_regwen = 1; bus.ex_ovf_chk = 1; bus.overflow = 1; bus.ex_rd = 3;
        tick();
`ifdef ALU_OVF_TRAP_EN
        chk("ovf.exc",    32'(bus.mem_exc), 1);
        chk("ovf.regwen", 32'(bus.mem_regwen), 0);
`else
        chk("ovf.exc",    32'(bus.mem_exc), 0);
        chk("ovf.regwen", 32'(bus.mem_regwen), 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.ex_valid      = ($urandom_range(0, 3) != 0);
            bus.portout       = $urandom;
            bus.zero          = 1'($urandom_range(0, 1));
            bus.negative      = 1'($urandom_range(0, 1));
            bus.overflow      = 1'($urandom_range(0, 1));
            bus.ex_pc         = $urandom;
            bus.ex_rd         = 5'($urandom_range(0, 31));
            bus.ex_regwen     = 1'($urandom_range(0, 1));
            bus.ex_dren       = 1'($urandom_range(0, 1));
            bus.ex_dwen       = 1'($urandom_range(0, 1));
            bus.ex_store_data = $urandom;
            bus.ex_brtype     = 3'($urandom_range(0, 7));
            bus.ex_brtarget   = $urandom;
            bus.ex_ovf_chk    = 1'($urandom_range(0, 1));
            bus.ex_halt       = ($urandom_range(0, 63) == 0);
            bus.flush         = ($urandom_range(0, 7) == 0);
            bus.stall         = ($urandom_range(0, 3) == 0);
            bus.dhit          = 1'($urandom_range(0, 1));
            tick();
            if (i % 97 == 96) async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
